// File: rtl/collision_scan_ctrl.sv
// Frame-driven collision scanner: checks the player square against each obstacle
// slot, one per clock, through a single shared overlap comparator, and runs the game-over FSM.
module collision_scan_ctrl #(
    parameter int SQUARE_SIZE = 30,
    parameter int N_OBJ       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  refresh_tick,
    input  logic [40*N_OBJ+19:0]  position,
    input  logic [N_OBJ-1:0]      active_mask,
    input  logic                  restart,
    output logic                  status,
    output logic                  game_over,
    output logic [N_OBJ-1:0]      hit_mask,
    output logic                  scan_busy,
    output logic                  scan_done,
    output logic                  overrun,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_start;
    logic [3:0]         r_index;
    logic [9:0]         r_ox [N_OBJ];
    logic [9:0]         r_oy [N_OBJ];
    logic [9:0]         r_px;
    logic [9:0]         r_py;
    logic [N_OBJ-1:0]   r_active;
    logic [N_OBJ-1:0]   r_work;
    logic [N_OBJ*20-1:0] w_unused_pos;

    genvar g;
    generate
        for (g = 0; g < N_OBJ; g++) begin : g_unused
            assign w_unused_pos[20*g +: 20] = position[40*g+20 +: 20];
        end
    endgenerate

    // Edges are formed in 11 bits so squares near x/y = 1023 do not wrap.
    logic [10:0] w_px_l, w_px_r, w_py_t, w_py_b;
    logic [10:0] w_ox_l, w_ox_r, w_oy_t, w_oy_b;
    logic        w_x_ov, w_y_ov, w_hit;

    assign w_px_l = {1'b0, r_px};
    assign w_py_t = {1'b0, r_py};
    assign w_ox_l = {1'b0, r_ox[r_index]};
    assign w_oy_t = {1'b0, r_oy[r_index]};
    assign w_px_r = w_px_l + 11'(SQUARE_SIZE - 1);
    assign w_py_b = w_py_t + 11'(SQUARE_SIZE - 1);
    assign w_ox_r = w_ox_l + 11'(SQUARE_SIZE - 1);
    assign w_oy_b = w_oy_t + 11'(SQUARE_SIZE - 1);
    assign w_x_ov = (w_px_l <= w_ox_r) && (w_ox_l <= w_px_r);
    assign w_y_ov = (w_py_t <= w_oy_b) && (w_oy_t <= w_py_b);
    assign w_hit  = w_x_ov && w_y_ov && r_active[r_index];

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (refresh_tick) begin
                    w_next  = SCAN;
                    w_start = 1'b1;
                end
            end
            SCAN: begin
                if (r_index == 4'(N_OBJ - 1)) w_next = DONE;
            end
            DONE: begin
                w_next = (r_work != '0) ? OVER : IDLE;
            end
            OVER: begin
                w_next = OVER;
            end
            default: w_next = IDLE;
        endcase
        if (restart) begin
            w_next  = IDLE;
            w_start = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_index   <= '0;
            r_work    <= '0;
            r_active  <= '0;
            r_px      <= '0;
            r_py      <= '0;
            hit_mask  <= '0;
            status    <= 1'b1;
            game_over <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < N_OBJ; i++) begin
                r_ox[i] <= '0;
                r_oy[i] <= '0;
            end
        end else if (restart) begin
            r_index   <= '0;
            hit_mask  <= '0;
            status    <= 1'b1;
            game_over <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (refresh_tick && (r_state == SCAN || r_state == DONE)) overrun <= 1'b1;
            if (w_start) begin
                // Snapshot keeps the scan consistent if the bus moves mid-frame.
                r_index  <= '0;
                r_work   <= '0;
                r_active <= active_mask;
                r_px     <= position[40*N_OBJ +: 10];
                r_py     <= position[40*N_OBJ+10 +: 10];
                for (int i = 0; i < N_OBJ; i++) begin
                    r_ox[i] <= position[40*i +: 10];
                    r_oy[i] <= position[40*i+10 +: 10];
                end
            end
            if (r_state == SCAN) begin
                r_work[r_index] <= w_hit;
                r_index         <= r_index + 4'd1;
            end
            if (r_state == DONE) begin
                hit_mask <= r_work;
                if (r_work != '0) begin
                    status    <= 1'b0;
                    game_over <= 1'b1;
                end
            end
        end
    end

    assign scan_busy = (r_state == SCAN);
    assign scan_done = (r_state == DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// Directed bench for collision_scan_ctrl: hand-computed hit masks, latency,
// overrun, restart and reset behaviour.
module tb_collision_scan_ctrl;

    logic         clk;
    logic         reset;
    logic         refresh_tick;
    logic [659:0] position;
    logic [15:0]  active_mask;
    logic         restart;
    logic         status;
    logic         game_over;
    logic [15:0]  hit_mask;
    logic         scan_busy;
    logic         scan_done;
    logic         overrun;
    logic [1:0]   dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    collision_scan_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .position     (position),
        .active_mask  (active_mask),
        .restart      (restart),
        .status       (status),
        .game_over    (game_over),
        .hit_mask     (hit_mask),
        .scan_busy    (scan_busy),
        .scan_done    (scan_done),
        .overrun      (overrun),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put_obj(input int i, input int x, input int y);
        position[40*i +: 10]    = 10'(x);
        position[40*i+10 +: 10] = 10'(y);
    endtask

    task automatic put_player(input int x, input int y);
        position[640 +: 10] = 10'(x);
        position[650 +: 10] = 10'(y);
    endtask

    task automatic fill_far();
        for (int i = 0; i < 16; i++) put_obj(i, 500, 400);
    endtask

    task automatic start_scan();
        @(negedge clk) refresh_tick = 1'b1;
        @(negedge clk) refresh_tick = 1'b0;
    endtask

    // Counts busy cycles from the current sample point up to scan_done, then checks results.
    task automatic finish_scan(input string tag, input int exp_busy, input logic [15:0] exp_hit);
        int busy_n = 0;
        int guard  = 0;
        while (!scan_done && guard < 40) begin
            if (scan_busy) busy_n++;
            guard++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, busy_n, exp_busy);
        check({tag, "_done_seen"}, scan_done, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, scan_done, 0);
        check({tag, "_hit_mask"}, hit_mask, exp_hit);
        check({tag, "_status"}, status, (exp_hit == 16'h0) ? 1 : 0);
        check({tag, "_game_over"}, game_over, (exp_hit != 16'h0) ? 1 : 0);
    endtask

    task automatic do_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
    endtask

    initial begin
        int busy_any;
        reset        = 1'b0;
        restart      = 1'b0;
        refresh_tick = 1'b0;
        active_mask  = 16'hFFFF;
        position     = '0;
        repeat (3) @(negedge clk);
        check("rst_status", status, 1);
        check("rst_game_over", game_over, 0);
        check("rst_hit_mask", hit_mask, 0);
        check("rst_busy", scan_busy, 0);
        check("rst_done", scan_done, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;

        // Shared edge pixel at x=129 counts as a hit.
        fill_far();
        put_player(100, 100);
        put_obj(3, 129, 100);
        start_scan();
        finish_scan("touch", 16, 16'h0008);

        // OVER ignores ticks entirely.
        start_scan();
        busy_any = 0;
        repeat (4) begin
            if (scan_busy) busy_any++;
            @(negedge clk);
        end
        check("over_no_busy", busy_any, 0);
        check("over_no_overrun", overrun, 0);
        check("over_hold_mask", hit_mask, 16'h0008);
        check("over_hold_go", game_over, 1);

        // Restart with a simultaneous tick: back to IDLE, nothing started.
        @(negedge clk) begin restart = 1'b1; refresh_tick = 1'b1; end
        @(negedge clk) begin restart = 1'b0; refresh_tick = 1'b0; end
        check("rs_status", status, 1);
        check("rs_game_over", game_over, 0);
        check("rs_hit_mask", hit_mask, 0);
        check("rs_busy", scan_busy, 0);
        @(negedge clk);
        check("rs_busy_later", scan_busy, 0);

        // One pixel apart: no hit, repeated frames every 20 cycles.
        put_obj(3, 130, 100);
        for (int k = 0; k < 3; k++) begin
            start_scan();
            finish_scan("gap", 16, 16'h0000);
            @(negedge clk);
        end
        check("gap_overrun", overrun, 0);

        // Snapshot isolates the scan from bus changes after the tick.
        start_scan();
        put_obj(5, 100, 100);
        finish_scan("snap", 16, 16'h0000);
        put_obj(5, 500, 400);

        // Empty active mask never hits, but still scans 16 slots.
        put_obj(3, 100, 100);
        active_mask = 16'h0000;
        start_scan();
        finish_scan("mask0", 16, 16'h0000);
        put_obj(3, 500, 400);
        active_mask = 16'hFFFF;

        // Right edge past 1023 must not wrap.
        put_player(1000, 10);
        put_obj(0, 1010, 20);
        start_scan();
        finish_scan("edge", 16, 16'h0001);
        do_restart();
        active_mask = 16'hFFFE;
        start_scan();
        finish_scan("edge_inact", 16, 16'h0000);
        active_mask = 16'hFFFF;
        put_obj(0, 500, 400);
        put_player(100, 100);

        // Second tick during SCAN sets overrun and is dropped.
        start_scan();
        repeat (4) @(negedge clk);
        refresh_tick = 1'b1;
        @(negedge clk) refresh_tick = 1'b0;
        check("ovr_flag", overrun, 1);
        finish_scan("ovr", 11, 16'h0000);
        busy_any = 0;
        repeat (4) begin
            if (scan_busy) busy_any++;
            @(negedge clk);
        end
        check("ovr_no_second", busy_any, 0);
        check("ovr_sticky", overrun, 1);

        // Asynchronous reset in the middle of a scan.
        put_obj(3, 129, 100);
        start_scan();
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", scan_busy, 0);
        check("mid_rst_done", scan_done, 0);
        check("mid_rst_status", status, 1);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_mask", hit_mask, 0);
        @(negedge clk) reset = 1'b1;
        start_scan();
        finish_scan("post_rst", 16, 16'h0008);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
